// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and encodings for the button arbiter
// Purpose: FSM state type, character action encodings and button bit
//          indices shared between the arbiter and the character FSM.
// Ports:   none (package).
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN0  = 2'b01,
    OWN1  = 2'b10,
    DRAIN = 2'b11
  } arb_state_t;

  // Character action encoding, identical to the character FSM's own.
  localparam logic [1:0] ACT_STAND = 2'b00;
  localparam logic [1:0] ACT_JUMP  = 2'b01;
  localparam logic [1:0] ACT_DIVE  = 2'b10;
  localparam logic [1:0] ACT_RUN   = 2'b11;

  // Bit positions inside a 3-bit button vector.
  localparam int BTN_JUMP = 2;
  localparam int BTN_RUN  = 1;
  localparam int BTN_DIVE = 0;

endpackage

// File: rtl/turn_counter.sv
// rtl/turn_counter.sv - saturating turn-length counter
// Purpose: counts cycles of the current turn, saturating at TURN_CYCLES-1.
// Ports:   clk     - system clock, rising edge
//          reset   - asynchronous active-low reset
//          clear   - synchronous clear to 0 (wins over enable)
//          enable  - advance the count by one, saturating
//          count   - current count
//          expired - count has reached TURN_CYCLES-1
module turn_counter #(
  parameter int TURN_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TURN_CYCLES - 1);

  assign expired = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_arbiter.sv
// rtl/button_arbiter.sv - two-player arbiter for the character action FSM
// Purpose: grants one player's buttons to the character FSM with bounded,
//          round-robin turns; handoffs wait until the character stands.
// Ports:   clk         - system clock, rising edge
//          reset       - asynchronous active-low reset
//          req         - req[i]: player i wants control
//          buttons_p0  - player 0 buttons {jump, run, dive}
//          buttons_p1  - player 1 buttons {jump, run, dive}
//          action      - current character action (stand/jump/dive/run)
//          buttons_out - buttons driven into the character FSM
//          grant       - one-hot owner, 00 when nobody owns
//          turn_cnt    - cycles elapsed in the current turn
//          draining    - waiting for stand before a handoff
module button_arbiter
  import arb_pkg::*;
#(
  parameter int TURN_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [2:0]       buttons_p0,
  input  logic [2:0]       buttons_p1,
  input  logic [1:0]       action,
  output logic [2:0]       buttons_out,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] turn_cnt,
  output logic             draining
);

  arb_state_t state;
  logic       last_owner;
  logic       expired;
  logic       cnt_clear;
  logic       cnt_enable;

  // The counter is held at zero outside a turn, so every entry into OWN
  // starts from 0 without needing the next-state decode.
  assign cnt_clear  = (state == IDLE) || (state == DRAIN);
  assign cnt_enable = (state == OWN0) || (state == OWN1);

  turn_counter #(
    .TURN_CYCLES(TURN_CYCLES),
    .CNT_W      (CNT_W)
  ) u_turn_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (turn_cnt),
    .expired(expired)
  );

  // Buttons are muted while draining so the character falls back to stand.
  always_comb begin
    buttons_out = 3'b000;
    if (!draining) begin
      if (grant == 2'b01) begin
        buttons_out = buttons_p0;
      end else if (grant == 2'b10) begin
        buttons_out = buttons_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      draining   <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie, the player who did not own last goes first.
          if (req[0] && (!req[1] || last_owner)) begin
            state      <= OWN0;
            grant      <= 2'b01;
            last_owner <= 1'b0;
          end else if (req[1]) begin
            state      <= OWN1;
            grant      <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        OWN0: begin
          if (!req[0] || (expired && req[1])) begin
            state    <= DRAIN;
            draining <= 1'b1;
          end
        end
        OWN1: begin
          if (!req[1] || (expired && req[0])) begin
            state    <= DRAIN;
            draining <= 1'b1;
          end
        end
        DRAIN: begin
          // grant still names the old owner; prefer the other player.
          if (action == ACT_STAND) begin
            draining <= 1'b0;
            if ((grant[0] && req[1]) || (!grant[0] && !req[0] && req[1])) begin
              state      <= OWN1;
              grant      <= 2'b10;
              last_owner <= 1'b1;
            end else if (req[0]) begin
              state      <= OWN0;
              grant      <= 2'b01;
              last_owner <= 1'b0;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= 2'b00;
          draining <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// tb/tb_button_arbiter.sv - self-checking bench for button_arbiter
module tb_button_arbiter;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [2:0] p0;
    logic [2:0] p1;
    logic [1:0] act;
    logic [1:0] exp_grant;
    logic [2:0] exp_out;
    logic [7:0] exp_cnt;
    logic       exp_drain;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [2:0] buttons_p0;
  logic [2:0] buttons_p1;
  logic [1:0] action;
  logic [2:0] buttons_out;
  logic [1:0] grant;
  logic [7:0] turn_cnt;
  logic       draining;

  int n_cmp;
  int n_bad;

  vec_t vecs[64];
  int   n_vec;

  button_arbiter #(
    .TURN_CYCLES(8),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .buttons_p0 (buttons_p0),
    .buttons_p1 (buttons_p1),
    .action     (action),
    .buttons_out(buttons_out),
    .grant      (grant),
    .turn_cnt   (turn_cnt),
    .draining   (draining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] g, input logic [2:0] o,
                           input logic [7:0] c, input logic d);
    check({tag, " grant"}, int'(grant), int'(g));
    check({tag, " buttons_out"}, int'(buttons_out), int'(o));
    check({tag, " turn_cnt"}, int'(turn_cnt), int'(c));
    check({tag, " draining"}, int'(draining), int'(d));
  endtask

  task automatic add(input logic rst, input logic [1:0] rq, input logic [2:0] b0,
                     input logic [2:0] b1, input logic [1:0] ac, input logic [1:0] g,
                     input logic [2:0] o, input logic [7:0] c, input logic d);
    vecs[n_vec].rst       = rst;
    vecs[n_vec].req       = rq;
    vecs[n_vec].p0        = b0;
    vecs[n_vec].p1        = b1;
    vecs[n_vec].act       = ac;
    vecs[n_vec].exp_grant = g;
    vecs[n_vec].exp_out   = o;
    vecs[n_vec].exp_cnt   = c;
    vecs[n_vec].exp_drain = d;
    n_vec++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_vec = 0;

    // Each row: inputs applied before an edge, outputs expected after it.
    // Player 0 alone: grant, counting, then drop request into drain/idle.
    add(1, 2'b00, 3'b100, 3'b010, 2'b00, 2'b00, 3'b000, 0, 0);
    add(1, 2'b01, 3'b100, 3'b010, 2'b00, 2'b01, 3'b100, 0, 0);
    add(1, 2'b01, 3'b110, 3'b010, 2'b00, 2'b01, 3'b110, 1, 0);
    add(1, 2'b01, 3'b001, 3'b010, 2'b00, 2'b01, 3'b001, 2, 0);
    add(1, 2'b00, 3'b001, 3'b010, 2'b01, 2'b01, 3'b000, 3, 1);
    add(1, 2'b00, 3'b001, 3'b010, 2'b01, 2'b01, 3'b000, 0, 1);
    add(1, 2'b00, 3'b001, 3'b010, 2'b00, 2'b00, 3'b000, 0, 0);
    // Fresh reset, then both request: player 0 first, turn expires mid-jump.
    add(0, 2'b00, 3'b100, 3'b010, 2'b00, 2'b00, 3'b000, 0, 0);
    add(1, 2'b11, 3'b100, 3'b010, 2'b00, 2'b01, 3'b100, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      add(1, 2'b11, 3'b100, 3'b010, 2'b00, 2'b01, 3'b100, 8'(i), 0);
    end
    add(1, 2'b11, 3'b100, 3'b010, 2'b01, 2'b01, 3'b000, 7, 1);
    add(1, 2'b11, 3'b100, 3'b010, 2'b01, 2'b01, 3'b000, 0, 1);
    add(1, 2'b11, 3'b100, 3'b010, 2'b00, 2'b10, 3'b010, 0, 0);
    add(1, 2'b11, 3'b100, 3'b011, 2'b00, 2'b10, 3'b011, 1, 0);

    reset      = 1'b0;
    req        = 2'b00;
    buttons_p0 = 3'b000;
    buttons_p1 = 3'b000;
    action     = 2'b00;
    #1;
    check_all("reset", 2'b00, 3'b000, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      req        = vecs[i].req;
      buttons_p0 = vecs[i].p0;
      buttons_p1 = vecs[i].p1;
      action     = vecs[i].act;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_out,
                vecs[i].exp_cnt, vecs[i].exp_drain);
    end

    // Player 1 alone for 20 cycles: turn extends, counter saturates at 7.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = 2'b10;
      @(posedge clk);
      #1;
      check_all($sformatf("sat%0d", i), 2'b10, 3'b011, 8'((2 + i > 7) ? 7 : 2 + i), 0);
    end

    // Drop request while diving, then reset asynchronously inside drain.
    @(negedge clk);
    req    = 2'b00;
    action = 2'b10;
    @(posedge clk);
    #1;
    check_all("drain_dive", 2'b10, 3'b000, 7, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 2'b00, 3'b000, 0, 0);
    @(posedge clk);
    #1;
    check_all("reset_held", 2'b00, 3'b000, 0, 0);
    @(negedge clk);
    reset  = 1'b1;
    req    = 2'b10;
    action = 2'b00;
    @(posedge clk);
    #1;
    check_all("after_reset", 2'b10, 3'b011, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
